// File: rtl/pool2d_stream.sv
// Streaming POOLxPOOL pooling (max or average, stride POOL) over a raster-order
// pixel stream, with one registered output slot and valid/ready on both sides.
module pool2d_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2,
  parameter int SIGNED = 0,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int LOG2P = $clog2(POOL);
  localparam int ACC_W = (MODE != 0) ? DATA_W + 2 * LOG2P : DATA_W;
  localparam int NK    = IMG_W / POOL;
  localparam int NR    = IMG_H / POOL;
  localparam int K_W   = (NK > 1) ? $clog2(NK) : 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN_END = COL_W'(NK * POOL - 1);
  localparam logic [ROW_W-1:0] ROW_WIN_END = ROW_W'(NR * POOL - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ACC_W-1:0]  acc_q [NK];

  logic              in_xfer, in_win, take;
  logic              first_px, last_px, greater;
  logic [K_W-1:0]    k;
  logic [ACC_W-1:0]  px_ext, acc_cur, new_val;

  // Only one output slot: a new input is taken whenever that slot frees up this cycle.
  assign s_ready  = !m_valid_q || m_ready;
  assign in_xfer  = s_valid && s_ready;
  assign in_win   = (col_q <= COL_WIN_END) && (row_q <= ROW_WIN_END);
  assign take     = in_xfer && !clear && in_win;
  assign first_px = (col_q[LOG2P-1:0] == '0) && (row_q[LOG2P-1:0] == '0);
  assign last_px  = (&col_q[LOG2P-1:0]) && (&row_q[LOG2P-1:0]);
  assign k        = K_W'(col_q >> LOG2P);
  assign acc_cur  = acc_q[k];

  always_comb begin
    px_ext = ACC_W'(s_data);
    if (SIGNED != 0 && s_data[DATA_W-1]) begin
      px_ext = px_ext | ~ACC_W'({DATA_W{1'b1}});
    end
    greater = 1'b0;
    if (SIGNED != 0) begin
      greater = $signed(px_ext) > $signed(acc_cur);
    end else begin
      greater = px_ext > acc_cur;
    end
    new_val = acc_cur;
    if (first_px) begin
      new_val = px_ext;
    end else if (MODE != 0) begin
      new_val = acc_cur + px_ext;
    end else if (greater) begin
      new_val = px_ext;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (in_xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // The top DATA_W bits are the max itself, or the sum floor-divided by POOL*POOL.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (take && last_px) begin
      m_valid_d = 1'b1;
      m_data_d  = new_val[ACC_W-1 -: DATA_W];
      m_last_d  = (col_q == COL_WIN_END) && (row_q == ROW_WIN_END);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      acc_q[k] <= new_val;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: four configurations side by side, table vectors,
// directed back-pressure/clear/reset sequences and random frames vs a window model.
module tb_pool2d_stream;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] s_data  [4];
  logic       s_valid [4];
  logic       m_ready [4];
  wire  [7:0] m_data  [4];
  wire        s_ready [4];
  wire        m_valid [4];
  wire        m_last  [4];

  // lane 0: 4x4 unsigned max, 1: 4x4 signed max, 2: 4x4 signed avg, 3: 5x5 unsigned max
  int lw [4] = '{4, 4, 4, 5};
  int lh [4] = '{4, 4, 4, 5};
  int ls [4] = '{0, 1, 1, 0};
  int lm [4] = '{0, 0, 1, 0};

  int checks = 0;
  int errors = 0;
  int bubble_pct = 0;
  bit rdy_mode = 1'b0;
  logic [10:0] exp_q[$];

  pool2d_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(0), .MODE(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_last(m_last[0]));
  pool2d_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(1), .MODE(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_last(m_last[1]));
  pool2d_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(1), .MODE(1)) u_l2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_last(m_last[2]));
  pool2d_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .POOL(2), .SIGNED(0), .MODE(0)) u_l3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data[3]), .s_valid(s_valid[3]),
    .s_ready(s_ready[3]), .m_data(m_data[3]), .m_valid(m_valid[3]), .m_ready(m_ready[3]),
    .m_last(m_last[3]));

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      for (int l = 0; l < 4; l++) m_ready[l] = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard: every output transfer must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < 4; l++) begin
        if (m_valid[l] && m_ready[l]) begin
          logic [10:0] got;
          logic [10:0] exp;
          got = {l[1:0], m_last[l], m_data[l]};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got lane %0d last %0d data %02h, required no output",
                     l, m_last[l], m_data[l]);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL out_data: got lane %0d last %0d data %02h, required lane %0d last %0d data %02h",
                       got[10:9], got[8], got[7:0], exp[10:9], exp[8], exp[7:0]);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: walk full windows in completion order, pool with plain integer arithmetic.
  function automatic void model(input int l, input int px[$]);
    int w = lw[l];
    int h = lh[l];
    int nw = w / 2;
    int nh = h / 2;
    for (int wr = 0; wr < nh; wr++) begin
      for (int wc = 0; wc < nw; wc++) begin
        int acc = 0;
        int v;
        logic last;
        for (int j = 0; j < 4; j++) begin
          v = px[(wr * 2 + j / 2) * w + wc * 2 + j % 2];
          if (ls[l] != 0 && v > 127) v = v - 256;
          if (j == 0) acc = v;
          else if (lm[l] != 0) acc = acc + v;
          else if (v > acc) acc = v;
        end
        if (lm[l] != 0) begin
          v = acc / 4;
          if ((acc % 4) != 0 && acc < 0) v = v - 1;
          acc = v;
        end
        last = (wr == nh - 1) && (wc == nw - 1);
        exp_q.push_back({l[1:0], last, acc[7:0]});
      end
    end
  endfunction

  // driver tasks
  task automatic push_px(input int l, input logic [7:0] d);
    int guard = 0;
    bit done = 1'b0;
    while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
      s_valid[l] = 1'b0;
      @(posedge clk); #1;
    end
    s_valid[l] = 1'b1;
    s_data[l]  = d;
    while (!done) begin
      @(negedge clk);
      if (s_ready[l]) begin
        @(posedge clk); #1;
        s_valid[l] = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        guard++;
        if (guard > 500) begin
          checks++;
          errors++;
          $display("FAIL push_timeout: lane %0d s_ready got 0 for 500 cycles, required 1", l);
          s_valid[l] = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic push_frame(input int l, input int px[$]);
    foreach (px[i]) push_px(l, px[i][7:0]);
  endtask

  task automatic rand_frame(input int l, input int hi, output int px[$]);
    px = {};
    for (int i = 0; i < lw[l] * lh[l]; i++) px.push_back($urandom_range(0, hi));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outputs outstanding, required 0", exp_q.size());
      exp_q = {};
    end
  endtask

  typedef struct {
    int lane;
    logic [7:0] a, b, c, d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int px[$];

    vecs[0]  = '{0, 8'hFD, 8'h80, 8'hFF, 8'hF9, 8'hFF};
    vecs[1]  = '{0, 8'h7F, 8'h80, 8'h01, 8'h00, 8'h80};
    vecs[2]  = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{0, 8'h05, 8'h09, 8'h09, 8'h02, 8'h09};
    vecs[4]  = '{1, 8'hFD, 8'h80, 8'hFF, 8'hF9, 8'hFF};
    vecs[5]  = '{1, 8'h7F, 8'h80, 8'h01, 8'h00, 8'h7F};
    vecs[6]  = '{1, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[7]  = '{2, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0B};
    vecs[8]  = '{2, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
    vecs[9]  = '{2, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    vecs[10] = '{2, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[11] = '{2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[12] = '{2, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[13] = '{1, 8'h01, 8'hF0, 8'h03, 8'h02, 8'h03};

    // reset
    rst_n = 1'b0;
    clear = 1'b0;
    for (int l = 0; l < 4; l++) begin
      s_valid[l] = 1'b0;
      s_data[l]  = 8'h00;
      m_ready[l] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      check("rst_m_valid", m_valid[l], 0);
      check("rst_m_last", m_last[l], 0);
      check("rst_m_data", m_data[l], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++) check("rst_s_ready", s_ready[l], 1);

    // 4x4 ramp, free-flowing output, 1-cycle latency
    px = {};
    for (int i = 0; i < 16; i++) px.push_back(i);
    model(0, px);
    for (int i = 0; i < 16; i++) begin
      push_px(0, 8'(i));
      check("lat_valid", m_valid[0], (i == 5 || i == 7 || i == 13 || i == 15) ? 1 : 0);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        check("lat_data", m_data[0], i);
        check("lat_last", m_last[0], (i == 15) ? 1 : 0);
      end
    end
    wait_drain();

    // same frame with output stalled after the first result
    model(0, px);
    for (int i = 0; i < 6; i++) push_px(0, 8'(i));
    m_ready[0] = 1'b0;
    fork
      begin
        for (int i = 6; i < 16; i++) push_px(0, 8'(i));
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_s_ready", s_ready[0], 0);
          check("bp_m_valid", m_valid[0], 1);
          check("bp_m_data", m_data[0], 5);
        end
        @(posedge clk); #1;
        m_ready[0] = 1'b1;
      end
    join
    wait_drain();

    // table vectors: window pattern tiled over the whole 4x4 frame
    rdy_mode   = 1'b1;
    bubble_pct = 20;
    foreach (vecs[v]) begin
      logic [7:0] win [4];
      win[0] = vecs[v].a;
      win[1] = vecs[v].b;
      win[2] = vecs[v].c;
      win[3] = vecs[v].d;
      for (int j = 0; j < 4; j++) exp_q.push_back({vecs[v].lane[1:0], (j == 3), vecs[v].exp});
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) push_px(vecs[v].lane, win[(r % 2) * 2 + (c % 2)]);
      wait_drain();
    end

    // random frames on every lane
    bubble_pct = 30;
    for (int l = 0; l < 4; l++) begin
      for (int f = 0; f < 3; f++) begin
        rand_frame(l, 255, px);
        model(l, px);
        push_frame(l, px);
      end
      wait_drain();
    end
    rdy_mode   = 1'b0;
    bubble_pct = 0;
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++) m_ready[l] = 1'b1;

    // 5x5 ragged frames back to back
    begin
      int px2[$];
      rand_frame(3, 255, px);
      rand_frame(3, 255, px2);
      model(3, px);
      model(3, px2);
      push_frame(3, px);
      push_frame(3, px2);
      wait_drain();
    end

    // clear mid-window, then clear together with an accepted pixel
    push_px(0, 8'd200);
    push_px(0, 8'd250);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    clear = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = 8'hFF;
    @(posedge clk); #1;
    clear = 1'b0;
    s_valid[0] = 1'b0;
    rand_frame(0, 100, px);
    model(0, px);
    push_frame(0, px);
    wait_drain();

    // clear while an output is pending keeps that output
    exp_q.push_back({2'd0, 1'b0, 8'd5});
    for (int i = 0; i < 5; i++) push_px(0, 8'(i));
    m_ready[0] = 1'b0;
    push_px(0, 8'd5);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_pend_valid", m_valid[0], 1);
    check("clr_pend_data", m_data[0], 5);
    m_ready[0] = 1'b1;
    rand_frame(0, 100, px);
    model(0, px);
    push_frame(0, px);
    wait_drain();

    // asynchronous reset with an output pending
    m_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) push_px(0, 8'(i + 40));
    check("prerst_valid", m_valid[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid[0], 0);
    check("async_rst_data", m_data[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("postrst_s_ready", s_ready[0], 1);
    check("postrst_valid", m_valid[0], 0);
    rand_frame(0, 255, px);
    model(0, px);
    push_frame(0, px);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
